// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-stream packet arbiter and its round-robin picker.
package axis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DROP = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    // Index width for n requesters, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx |= 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first requester at or after last_idx+1, wrapping.
module rr_picker
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_SRC-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] sel;
        gnt_onehot = '0;
        found      = 1'b0;
        sel        = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            sel = IDX_W'((int'(last_idx) + k) % NUM_SRC);
            if (!found && req[sel]) begin
                found           = 1'b1;
                gnt_onehot[sel] = 1'b1;
            end
        end
        gnt_idx = IDX_W'(onehot_to_idx(8'(gnt_onehot)));
        any     = |req;
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-locked round-robin arbiter feeding the eth_mac AXI-stream input, with
// inter-packet gap insertion and truncation of packets longer than MAX_BEATS.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 1024,
    parameter int GAP_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    input  logic [NUM_SRC-1:0]            s_tlast,
    input  logic [NUM_SRC-1:0]            s_tuser,
    output logic [NUM_SRC-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    output logic                          m_tuser,
    input  logic                          m_tready,
    output logic [NUM_SRC-1:0]            grant,
    output logic                          busy,
    output logic                          pkt_done,
    output logic                          err_trunc
);

    localparam int IDX_W  = idx_w(NUM_SRC);
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam arb_state_t        POST_PKT  = (GAP_CYCLES == 0) ? IDLE : GAP;

    arb_state_t            state;
    logic [IDX_W-1:0]      last_idx, g, pick_idx;
    logic [NUM_SRC-1:0]    pick_oh;
    logic                  pick_any;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  at_max;
    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_data[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_picker #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_pick (
        .req        (s_tvalid),
        .last_idx   (last_idx),
        .gnt_onehot (pick_oh),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    assign at_max = (beat_cnt == BEAT_LAST);
    assign busy   = (state == XFER) || (state == DROP);

    // Payload path is a pure mux; the source must hold data stable under backpressure.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;
        s_tready = '0;
        pkt_done = 1'b0;
        case (state)
            XFER: begin
                m_tdata  = src_data[g];
                m_tvalid = s_tvalid[g];
                m_tuser  = s_tuser[g];
                m_tlast  = s_tlast[g] | at_max;
                s_tready = grant & {NUM_SRC{m_tready}};
                pkt_done = m_tvalid & m_tready & m_tlast;
            end
            DROP:    s_tready = grant;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            g         <= '0;
            last_idx  <= IDX_W'(NUM_SRC - 1);
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            err_trunc <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    grant    <= pick_oh;
                    g        <= pick_idx;
                    beat_cnt <= '0;
                    state    <= XFER;
                end
                XFER: if (m_tvalid && m_tready) begin
                    if (s_tlast[g]) begin
                        last_idx <= g;
                        grant    <= '0;
                        beat_cnt <= '0;
                        state    <= POST_PKT;
                    end else if (at_max) begin
                        // Grant stays with the runaway source while its tail is drained.
                        err_trunc <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= DROP;
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                DROP: if (s_tvalid[g] && s_tlast[g]) begin
                    last_idx <= g;
                    grant    <= '0;
                    state    <= POST_PKT;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one AXI-stream payload input of eth_mac between NUM_SRC requesters (axis_master, sensor/LVDS capture paths, etc.).
- Locks the grant for a whole packet, from first beat to tlast.
- Enforces a minimum idle gap between packets and truncates runaway packets longer than MAX_BEATS.
- Sits in the tx_data_clk domain, directly upstream of eth_mac s_axis_*.

Parameters:
- NUM_SRC, 2, number of requesters (2..8).
- DATA_WIDTH, 8, tdata width per source.
- MAX_BEATS, 1024, maximum beats per packet before forced truncation (>=2).
- GAP_CYCLES, 4, idle cycles inserted after every completed or truncated packet (0 allowed).

Ports:
- clk  in  1  stream clock (eth_mac tx_data_clk).
- reset  in  1  asynchronous, active-high reset.
- s_tdata  in  NUM_SRC*DATA_WIDTH  flattened source data; source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  in  NUM_SRC  per-source valid.
- s_tlast  in  NUM_SRC  per-source last.
- s_tuser  in  NUM_SRC  per-source user (start-of-frame marker, passed through).
- s_tready  out  NUM_SRC  per-source ready.
- m_tdata  out  DATA_WIDTH  to eth_mac.
- m_tvalid  out  1
- m_tlast  out  1
- m_tuser  out  1
- m_tready  in  1  from eth_mac.
- grant  out  NUM_SRC  one-hot current owner; 0 when none.
- busy  out  1  high in ARB_XFER or DROP.
- pkt_done  out  1  one-cycle pulse on the accepted m_tlast beat.
- err_trunc  out  1  sticky; set on truncation, cleared only by reset.

Behaviour:
- Reset (async assert, sync release) values:
  - state = IDLE; grant = 0; last_idx = NUM_SRC-1, so source 0 wins first.
  - beat_cnt = 0; gap_cnt = 0.
  - All outputs 0, including s_tready and m_tvalid.
- Reset mid-packet abandons the packet. No m_tlast is emitted and the source sees s_tready drop.
- IDLE:
  - m_tvalid = 0 and s_tready = 0.
  - If any s_tvalid is high, select the first requester at or after index (last_idx+1) mod NUM_SRC, wrapping around.
  - Register the winner in grant and go to XFER.
  - Arbitration latency is exactly 1 cycle, from s_tvalid high in IDLE to m_tvalid in XFER.
- XFER:
  - Combinational mux: m_tdata/m_tvalid/m_tuser equal the granted source's signals.
  - m_tlast = s_tlast[g] OR (beat_cnt == MAX_BEATS-1).
  - s_tready[g] = m_tready; all other s_tready = 0.
  - On each accepted beat (m_tvalid & m_tready), beat_cnt increments.
  - Accepted beat with s_tlast[g] = 1: pkt_done pulses; last_idx = g; beat_cnt = 0; grant = 0; next state GAP, or IDLE if GAP_CYCLES = 0.
  - Accepted beat at beat_cnt == MAX_BEATS-1 with s_tlast[g] = 0: forced m_tlast; pkt_done pulses; err_trunc set; next state DROP.
  - s_tlast on exactly the MAX_BEATS-th beat is normal completion and does not set err_trunc.
- DROP:
  - m_tvalid = 0; s_tready[g] = 1, so the rest of the packet is discarded.
  - On s_tvalid[g] & s_tlast[g]: last_idx = g; grant = 0; go to GAP (or IDLE if GAP_CYCLES = 0).
- GAP:
  - All s_tready = 0 and m_tvalid = 0.
  - gap_cnt counts 0..GAP_CYCLES-1, then clears; go to IDLE.
  - Minimum dead time from the last accepted beat to the next m_tvalid is GAP_CYCLES+1 cycles.
- Backpressure: m_tready low holds everything. Data is not registered, so holding requires the source to keep its data stable (AXI-S rule).
- A granted source dropping s_tvalid mid-packet keeps the grant. There is no timeout.
- The grant never changes except at tlast, truncation completion or reset.
- Non-granted sources asserting tvalid wait and are never starved: round-robin bounds the wait to NUM_SRC-1 packets.
- Counter widths:
  - beat_cnt is $clog2(MAX_BEATS+1) bits.
  - gap_cnt is max(1, $clog2(GAP_CYCLES+1)) bits.

Decomposition:
- Package axis_arb_pkg holds:
  - State enum {IDLE, XFER, DROP, GAP}.
  - IDX_W = $clog2(NUM_SRC), with a minimum of 1.
  - A one-hot-to-index function.
- Sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: req[NUM_SRC], last_idx.
  - Outputs: gnt_onehot, gnt_idx, any.
  - Reused by future iic/mdio command arbiters.

Test Plan:
- Single source 0 sends 4-beat packet A0..A3 with m_tready always 1 -> m_tvalid rises 1 cycle after s_tvalid; m_tdata = A0..A3 on consecutive cycles; m_tlast on A3; pkt_done one pulse; grant = 01 then 00; next m_tvalid no earlier than 5 cycles after A3 (GAP_CYCLES = 4).
- Both sources continuously request 3-beat packets -> grant sequence after reset is 01,10,01,10; no interleaving within a packet; s_tready of the waiting source stays 0 throughout.
- m_tready toggles 1010... during a source-1 packet of 0x10..0x17 -> output sequence exactly 0x10..0x17 with no duplication or loss; beat count = 8.
- MAX_BEATS = 16 with source 0 sending a 20-beat packet -> m_tlast forced on beat 16; err_trunc = 1; beats 17..20 are accepted with m_tvalid = 0; then GAP, then source 1 is served.
- Reset asserted mid-packet at beat 2 -> same-cycle (async) m_tvalid = 0, s_tready = 0, grant = 0, err_trunc = 0; after release, source 0 wins the first arbitration.
- GAP_CYCLES = 0 with back-to-back packets from source 0 only -> next m_tvalid 2 cycles after the tlast beat (IDLE + arbitration).
